nwnr_fifo: RTL and testbench

- Parametrised multi-port FIFO: successor to the fixed 2-in/2-out queue.
- Generalises the write-lane count, read-lane count, depth (any integer, not only powers of two) and data width.
- Adds per-lane ready/valid flow control, in-order compaction of sparse write masks, and sticky overflow/underflow error flags.
- Used as the wide instruction/uop buffer between fetch/decode and dispatch stages in the cosim model.

---
 rtl/nwnr_fifo.sv | 161 ++++++++++++++++
 tb/tb_nwnr_fifo.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/nwnr_fifo.sv
// Parametrised N-write / M-read FIFO with lane compaction, ready/valid flags and sticky error flags.
// Optional same-cycle write credit and read bypass are enabled with NWNR_FIFO_BYPASS_EN.
module nwnr_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int WR_PORTS   = 2,
    parameter int RD_PORTS   = 2,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WR_PORTS-1:0]            wr_en_i,
    input  logic [WR_PORTS*DATA_WIDTH-1:0] wr_data_i,
    output logic [WR_PORTS-1:0]            wr_ready_o,
    input  logic [RD_PORTS-1:0]            rd_en_i,
    output logic [RD_PORTS*DATA_WIDTH-1:0] rd_data_o,
    output logic [RD_PORTS-1:0]            rd_valid_o,
    output logic [CNT_WIDTH-1:0]           count_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic                           overflow_o,
    output logic                           underflow_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Operands are always below 2*DEPTH, so one conditional subtract suffices.
    function automatic int wrap_idx(input int v);
        return (v >= DEPTH) ? v - DEPTH : v;
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      head_reg, tail_reg;
    logic [CNT_WIDTH-1:0]  count_reg;
    logic                  overflow_reg, underflow_reg;

    int                    lead, free_slots, wr_k, n_wr, avail, pops;
    logic                  prefix_ok, ov_ev, un_ev;
    logic [WR_PORTS-1:0]   wr_acc;
    logic [PTR_W-1:0]      wr_addr [WR_PORTS];
    logic [DATA_WIDTH-1:0] rd_lane [RD_PORTS];
    logic [RD_PORTS-1:0]   rd_vis;
`ifdef NWNR_FIFO_BYPASS_EN
    int                    byp_idx;
`endif

    // Leading-ones run of the pop mask; any 1 after a 0 breaks the prefix rule.
    always_comb begin
        lead      = 0;
        prefix_ok = 1'b1;
        for (int i = 0; i < RD_PORTS; i++) begin
            if (rd_en_i[i]) begin
                if (lead == i) lead = lead + 1;
                else           prefix_ok = 1'b0;
            end
        end
    end

    always_comb begin
`ifdef NWNR_FIFO_BYPASS_EN
        free_slots = DEPTH - int'(count_reg)
                   + ((lead < int'(count_reg)) ? lead : int'(count_reg));
`else
        free_slots = DEPTH - int'(count_reg);
`endif
        wr_k   = 0;
        n_wr   = 0;
        ov_ev  = 1'b0;
        wr_acc = '0;
        for (int i = 0; i < WR_PORTS; i++) begin
            wr_addr[i] = '0;
            if (wr_en_i[i]) begin
                if (wr_k < free_slots) begin
                    wr_acc[i]  = 1'b1;
                    wr_addr[i] = PTR_W'(wrap_idx(int'(tail_reg) + wr_k));
                    n_wr       = n_wr + 1;
                end else begin
                    ov_ev = 1'b1;
                end
                wr_k = wr_k + 1;
            end
        end
    end

    always_comb begin
`ifdef NWNR_FIFO_BYPASS_EN
        avail = int'(count_reg) + n_wr;
`else
        avail = int'(count_reg);
`endif
        pops   = (lead < avail) ? lead : avail;
        un_ev  = !prefix_ok;
        rd_vis = '0;
        for (int i = 0; i < RD_PORTS; i++) begin
            rd_vis[i]  = (i < avail);
            rd_lane[i] = '0;
            if (rd_en_i[i] && (i >= avail)) un_ev = 1'b1;
            if (i < int'(count_reg))
                rd_lane[i] = mem[PTR_W'(wrap_idx(int'(head_reg) + i))];
        end
`ifdef NWNR_FIFO_BYPASS_EN
        // Lanes past the stored entries show accepted writes in compacted order.
        byp_idx = int'(count_reg);
        for (int w = 0; w < WR_PORTS; w++) begin
            if (wr_acc[w]) begin
                for (int i = 0; i < RD_PORTS; i++)
                    if (i == byp_idx) rd_lane[i] = wr_data_i[w*DATA_WIDTH +: DATA_WIDTH];
                byp_idx = byp_idx + 1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            head_reg      <= PTR_W'(wrap_idx(int'(head_reg) + pops));
            tail_reg      <= PTR_W'(wrap_idx(int'(tail_reg) + n_wr));
            count_reg     <= CNT_WIDTH'(int'(count_reg) + n_wr - pops);
            overflow_reg  <= overflow_reg | ov_ev;
            underflow_reg <= underflow_reg | un_ev;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < WR_PORTS; i++)
            if (wr_acc[i]) mem[wr_addr[i]] <= wr_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end

    generate
        for (genvar gi = 0; gi < WR_PORTS; gi++) begin : g_wr_ready
            assign wr_ready_o[gi] = (free_slots > gi);
        end
        for (genvar gi = 0; gi < RD_PORTS; gi++) begin : g_rd_lane
            assign rd_valid_o[gi]                          = rd_vis[gi];
            assign rd_data_o[gi*DATA_WIDTH +: DATA_WIDTH] = rd_lane[gi];
        end
    endgenerate

    assign count_o     = count_reg;
    assign full_o      = (count_reg == CNT_WIDTH'(DEPTH));
    assign empty_o     = (count_reg == '0);
    assign overflow_o  = overflow_reg;
    assign underflow_o = underflow_reg;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (int'(count_reg) <= DEPTH);
            assert (wrap_idx(int'(tail_reg) + DEPTH - int'(head_reg))
                    == ((int'(count_reg) == DEPTH) ? 0 : int'(count_reg)));
        end
    end
`endif

endmodule

// File: tb/tb_nwnr_fifo.sv
// Directed + random bench for nwnr_fifo: queue scoreboard per instance (DEPTH=16 and DEPTH=5).
module tb_nwnr_fifo;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, rst_b = 1'b1;
    logic [1:0]  we_a = '0, we_b = '0, re_a = '0, re_b = '0;
    logic [63:0] wd_a = '0, wd_b = '0;
    logic [63:0] rdd_a, rdd_b;
    logic [1:0]  rv_a, rv_b, rdy_a, rdy_b;
    logic [4:0]  cnt_a;
    logic [2:0]  cnt_b;
    logic        full_a, full_b, empty_a, empty_b, ov_a, ov_b, un_a, un_b;

    nwnr_fifo u_a (
        .clk(clk), .rst(rst_a), .wr_en_i(we_a), .wr_data_i(wd_a), .wr_ready_o(rdy_a),
        .rd_en_i(re_a), .rd_data_o(rdd_a), .rd_valid_o(rv_a), .count_o(cnt_a),
        .full_o(full_a), .empty_o(empty_a), .overflow_o(ov_a), .underflow_o(un_a)
    );

    nwnr_fifo #(.DEPTH(5)) u_b (
        .clk(clk), .rst(rst_b), .wr_en_i(we_b), .wr_data_i(wd_b), .wr_ready_o(rdy_b),
        .rd_en_i(re_b), .rd_data_o(rdd_b), .rd_valid_o(rv_b), .count_o(cnt_b),
        .full_o(full_b), .empty_o(empty_b), .overflow_o(ov_b), .underflow_o(un_b)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] qa[$], qb[$];
    bit          ova = 0, una = 0, ovb = 0, unb = 0;
    logic [31:0] seq = 32'h1000;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input int inst, input string tag, input int size, input int depth,
                             input bit ov, input bit un, input logic [63:0] ed);
        logic [63:0] o_cnt, o_rv, o_rdy, o_full, o_empty, o_ov, o_un, o_dat;
        logic [1:0]  ev, er;
        ev = '0;
        er = '0;
        for (int i = 0; i < 2; i++) begin
            if (i < size) ev[i] = 1'b1;
            if (depth - size > i) er[i] = 1'b1;
        end
        if (inst == 0) begin
            o_cnt = 64'(cnt_a); o_rv = 64'(rv_a); o_rdy = 64'(rdy_a); o_full = 64'(full_a);
            o_empty = 64'(empty_a); o_ov = 64'(ov_a); o_un = 64'(un_a); o_dat = rdd_a;
        end else begin
            o_cnt = 64'(cnt_b); o_rv = 64'(rv_b); o_rdy = 64'(rdy_b); o_full = 64'(full_b);
            o_empty = 64'(empty_b); o_ov = 64'(ov_b); o_un = 64'(un_b); o_dat = rdd_b;
        end
        check({tag, ".count"},     o_cnt,   64'(size));
        check({tag, ".rd_valid"},  o_rv,    64'(ev));
        check({tag, ".wr_ready"},  o_rdy,   64'(er));
        check({tag, ".full"},      o_full,  64'(size == depth));
        check({tag, ".empty"},     o_empty, 64'(size == 0));
        check({tag, ".overflow"},  o_ov,    64'(ov));
        check({tag, ".underflow"}, o_un,    64'(un));
        check({tag, ".rd_data"},   o_dat,   ed);
    endtask

    // Drive one cycle, compare pre-edge outputs against the scoreboard, then advance the model.
    task automatic step(input int inst, input logic [1:0] we, input logic [31:0] d0,
                        input logic [31:0] d1, input logic [1:0] re, input string tag);
        logic [31:0] q[$];
        logic [31:0] acc[$];
        logic [63:0] ed;
        int          depth, size, free, k, lead, pops;
        bit          ov, un;
        @(negedge clk);
        if (inst == 0) begin
            q = qa; depth = 16; ov = ova; un = una;
            we_a = we; wd_a = {d1, d0}; re_a = re;
        end else begin
            q = qb; depth = 5; ov = ovb; un = unb;
            we_b = we; wd_b = {d1, d0}; re_b = re;
        end
        #1;
        size = q.size();
        free = depth - size;
        ed = '0;
        for (int i = 0; i < 2; i++)
            if (i < size) ed[i*32 +: 32] = q[i];
        check_all(inst, tag, size, depth, ov, un, ed);
        k = 0;
        for (int i = 0; i < 2; i++) begin
            if (we[i]) begin
                if (k < free) acc.push_back((i == 0) ? d0 : d1);
                else          ov = 1;
                k++;
            end
        end
        lead = re[0] ? (re[1] ? 2 : 1) : 0;
        if (re[1] && !re[0]) un = 1;
        for (int i = 0; i < 2; i++)
            if (re[i] && i >= size) un = 1;
        pops = (lead < size) ? lead : size;
        repeat (pops) void'(q.pop_front());
        foreach (acc[i]) q.push_back(acc[i]);
        if (inst == 0) begin qa = q; ova = ov; una = un; end
        else           begin qb = q; ovb = ov; unb = un; end
    endtask

    task automatic pulse_rst(input int inst, input logic [1:0] we, input logic [1:0] re,
                             input string tag);
        @(negedge clk);
        if (inst == 0) begin rst_a = 1'b1; we_a = we; re_a = re; wd_a = {$urandom, $urandom}; end
        else           begin rst_b = 1'b1; we_b = we; re_b = re; wd_b = {$urandom, $urandom}; end
        #1;
        check_all(inst, tag, 0, (inst == 0) ? 16 : 5, 0, 0, 64'h0);
        if (inst == 0) begin qa.delete(); ova = 0; una = 0; end
        else           begin qb.delete(); ovb = 0; unb = 0; end
        @(negedge clk);
        if (inst == 0) begin rst_a = 1'b0; we_a = '0; re_a = '0; end
        else           begin rst_b = 1'b0; we_b = '0; re_b = '0; end
    endtask

    function automatic logic [31:0] nxt();
        seq = seq + 32'h11;
        return seq;
    endfunction

    initial begin
        pulse_rst(0, 2'b00, 2'b00, "reset_a");
        pulse_rst(1, 2'b00, 2'b00, "reset_b");

        // Dual write, then both lanes visible next cycle
        step(0, 2'b11, 32'hAAAA_0001, 32'hBBBB_0002, 2'b00, "t1_write");
        step(0, 2'b00, 32'h0, 32'h0, 2'b00, "t1_read");
        step(0, 2'b00, 32'h0, 32'h0, 2'b11, "t1_pop2");
        // Sparse mask compacts lane1 data to the head
        step(0, 2'b10, 32'hDEAD_0000, 32'hCCCC_0003, 2'b00, "t2_sparse");
        step(0, 2'b00, 32'h0, 32'h0, 2'b00, "t2_read");
        // Over-pop with one entry present
        step(0, 2'b00, 32'h0, 32'h0, 2'b11, "t5_overpop");
        step(0, 2'b00, 32'h0, 32'h0, 2'b00, "t5_after");
        // Fill to 15, then a dual write where only lane0 fits
        for (int n = 0; n < 7; n++) step(0, 2'b11, nxt(), nxt(), 2'b00, "fill_a");
        step(0, 2'b01, nxt(), nxt(), 2'b00, "fill_a15");
        step(0, 2'b11, nxt(), nxt(), 2'b00, "t4_overflow");
        step(0, 2'b00, 32'h0, 32'h0, 2'b00, "t4_full");
        // Full and pop together: writes see pre-pop space
        step(0, 2'b11, nxt(), nxt(), 2'b11, "full_and_pop");
        for (int n = 0; n < 3; n++) step(0, 2'b00, 32'h0, 32'h0, 2'b11, "drain_a");
        step(0, 2'b00, 32'h0, 32'h0, 2'b01, "drain_a1");
        step(0, 2'b00, 32'h0, 32'h0, 2'b00, "cnt7");
        // Reset mid-stream with traffic present
        pulse_rst(0, 2'b11, 2'b01, "t6_rst");
        step(0, 2'b00, 32'h0, 32'h0, 2'b00, "t6_after");
        step(0, 2'b00, 32'h0, 32'h0, 2'b10, "t5_nonprefix");
        step(0, 2'b00, 32'h0, 32'h0, 2'b00, "t5_nonprefix_chk");

        // DEPTH=5 wrap scenario
        step(1, 2'b11, nxt(), nxt(), 2'b00, "t3_w2");
        step(1, 2'b11, nxt(), nxt(), 2'b00, "t3_w4");
        step(1, 2'b01, nxt(), nxt(), 2'b00, "t3_w5");
        step(1, 2'b00, 32'h0, 32'h0, 2'b11, "t3_full_pop2");
        step(1, 2'b11, nxt(), nxt(), 2'b00, "t3_wrap_w2");
        step(1, 2'b00, 32'h0, 32'h0, 2'b11, "t3_rd_a");
        step(1, 2'b00, 32'h0, 32'h0, 2'b11, "t3_rd_b");
        step(1, 2'b00, 32'h0, 32'h0, 2'b01, "t3_rd_c");
        step(1, 2'b00, 32'h0, 32'h0, 2'b00, "t3_empty");
        for (int n = 0; n < 40; n++)
            step(1, 2'($urandom_range(0, 3)), $urandom, $urandom,
                 2'($urandom_range(0, 3)), "rand_b");
        step(1, 2'b00, 32'h0, 32'h0, 2'b00, "rand_b_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
